// File: rtl/test_mem_mport.sv
// -----------------------------------------------------------------------------
// test_mem_mport
//
// Multi-port simulation memory for processor test harnesses. There are
// p_num_ports independent val/rdy request/response port pairs, and all of them
// share one array of 32-bit words. Each port keeps a small in-order response
// queue. Each queue entry holds the finished response fields and a countdown
// that sets when the response may leave.
//
// Optional feature: define TEST_MEM_RAND_DELAY_EN to add a per-port 16-bit LFSR.
// The LFSR adds 0..p_rand_max extra cycles of latency to each request. With the
// macro undefined, latency is fixed at p_latency and no LFSR logic is built.
//
// Ports
//   clk       in   1                   clock, all state on posedge
//   rst       in   1                   asynchronous, active-high reset
//   req_msg   in   [p_num_ports] x 77  {type_[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}
//   req_val   in   [p_num_ports]       request valid
//   req_rdy   out  [p_num_ports]       request ready
//   resp_msg  out  [p_num_ports] x 47  {type_[2:0], opaque[7:0], test[1:0], len[1:0], data[31:0]}
//   resp_val  out  [p_num_ports]       response valid
//   resp_rdy  in   [p_num_ports]       response ready
// -----------------------------------------------------------------------------
module test_mem_mport #(
    parameter int p_num_ports   = 2,
    parameter int p_depth_words = 4096,
    parameter int p_latency     = 1,
    parameter int p_queue_depth = 2,
    parameter int p_rand_max    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [p_num_ports-1:0][76:0] req_msg,
    input  logic [p_num_ports-1:0]       req_val,
    output logic [p_num_ports-1:0]       req_rdy,
    output logic [p_num_ports-1:0][46:0] resp_msg,
    output logic [p_num_ports-1:0]       resp_val,
    input  logic [p_num_ports-1:0]       resp_rdy
);

    localparam int AW = (p_depth_words > 1) ? $clog2(p_depth_words) : 1;
    localparam int QW = (p_queue_depth > 1) ? $clog2(p_queue_depth) : 1;
    localparam int NW = $clog2(p_queue_depth + 1);
`ifdef TEST_MEM_RAND_DELAY_EN
    localparam int MAX_CD = p_latency - 1 + p_rand_max;
`else
    localparam int MAX_CD = p_latency - 1;
`endif
    localparam int CW = (MAX_CD > 0) ? $clog2(MAX_CD + 1) : 1;

    localparam logic [2:0] TYPE_READ  = 3'd0;
    localparam logic [2:0] TYPE_WRITE = 3'd1;
    localparam logic [2:0] TYPE_INIT  = 3'd2;

    logic [31:0] mem [p_depth_words];

    // Per-port request decode
    logic [AW-1:0] word_idx [p_num_ports];
    logic [3:0]    lane_en  [p_num_ports];
    logic [31:0]   wr_lanes [p_num_ports];
    logic          is_write [p_num_ports];
    logic [46:0]   enq_msg  [p_num_ports];
    logic [CW-1:0] enq_cd   [p_num_ports];
    logic [p_num_ports-1:0] accept;
    logic [p_num_ports-1:0] deq;
    logic [p_num_ports-1:0] unused_addr_hi;

    // Per-port response queues
    logic [46:0]   q_msg [p_num_ports][p_queue_depth];
    logic [CW-1:0] q_cd  [p_num_ports][p_queue_depth];
    logic [QW-1:0] head  [p_num_ports];
    logic [QW-1:0] tail  [p_num_ports];
    logic [NW-1:0] count [p_num_ports];

    function automatic logic [2:0] num_bytes(input logic [1:0] len);
        return (len == 2'd0) ? 3'd4 : {1'b0, len};
    endfunction

    // Byte lanes touched by an access. Lanes past 3 fall off the word and are
    // not wrapped back around.
    function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] len);
        logic [3:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            if ((k >= int'(off)) && (k < int'(off) + int'(num_bytes(len))))
                m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [1:0] len);
        case (len)
            2'd1:    return 32'h0000_00FF;
            2'd2:    return 32'h0000_FFFF;
            2'd3:    return 32'h00FF_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [QW-1:0] ptr_inc(input logic [QW-1:0] p);
        if (int'(p) == p_queue_depth - 1)
            return '0;
        return p + QW'(1);
    endfunction

`ifdef TEST_MEM_RAND_DELAY_EN
    // Fibonacci LFSR with taps 16,14,13,11. It steps once per accepted request.
    logic [15:0] lfsr [p_num_ports];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < p_num_ports; p++)
                lfsr[p] <= 16'hACE1 ^ 16'(p);
        end else begin
            for (int p = 0; p < p_num_ports; p++) begin
                if (accept[p])
                    lfsr[p] <= {lfsr[p][14:0], lfsr[p][15] ^ lfsr[p][13] ^ lfsr[p][12] ^ lfsr[p][10]};
            end
        end
    end
`endif

    for (genvar g = 0; g < p_num_ports; g++) begin : g_port
        logic [2:0]  typ;
        logic [1:0]  off;
        logic [1:0]  len;
        logic [31:0] rd_data;

        assign typ = req_msg[g][76:74];
        assign off = req_msg[g][35:34];
        assign len = req_msg[g][33:32];

        // Address bits above the array index are ignored, so addresses alias.
        assign word_idx[g]       = req_msg[g][36 +: AW];
        assign unused_addr_hi[g] = ^req_msg[g][65 : 36 + AW];

        assign lane_en[g]  = lane_mask(off, len);
        assign wr_lanes[g] = req_msg[g][31:0] << {off, 3'b000};
        assign is_write[g] = (typ == TYPE_WRITE) || (typ == TYPE_INIT);

        // The array is read before the edge, so a read sees the old contents
        // even when another port writes the same word in the same cycle.
        assign rd_data    = (mem[word_idx[g]] >> {off, 3'b000}) & byte_mask(len);
        assign enq_msg[g] = {typ, req_msg[g][73:66], 2'b00, len,
                             (typ == TYPE_READ) ? rd_data : 32'h0};

`ifdef TEST_MEM_RAND_DELAY_EN
        assign enq_cd[g] = CW'(p_latency - 1 + int'(lfsr[g][7:0]) % (p_rand_max + 1));
`else
        assign enq_cd[g] = CW'(p_latency - 1);
`endif

        // req_rdy looks only at the registered count. A dequeue while the
        // queue is full does not free a slot in that same cycle.
        assign req_rdy[g]  = !rst && (int'(count[g]) < p_queue_depth);
        assign resp_val[g] = (count[g] != '0) && (q_cd[g][head[g]] == '0);
        assign resp_msg[g] = resp_val[g] ? q_msg[g][head[g]] : '0;
        assign accept[g]   = req_val[g] & req_rdy[g];
        assign deq[g]      = resp_val[g] & resp_rdy[g];
    end

    // Ports are applied in ascending order, so on a byte conflict the highest
    // port index wins. Reset never clears the array.
    always_ff @(posedge clk) begin
        for (int p = 0; p < p_num_ports; p++) begin
            for (int k = 0; k < 4; k++) begin
                if (accept[p] && is_write[p] && lane_en[p][k])
                    mem[word_idx[p]][8*k +: 8] <= wr_lanes[p][8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < p_num_ports; p++) begin
            if (accept[p])
                q_msg[p][tail[p]] <= enq_msg[p];
        end
    end

    // Every countdown decrements, including those behind a stalled head.
    // Those entries then leave back-to-back once the head drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < p_num_ports; p++) begin
                head[p]  <= '0;
                tail[p]  <= '0;
                count[p] <= '0;
                for (int e = 0; e < p_queue_depth; e++)
                    q_cd[p][e] <= '0;
            end
        end else begin
            for (int p = 0; p < p_num_ports; p++) begin
                for (int e = 0; e < p_queue_depth; e++) begin
                    if (q_cd[p][e] != '0)
                        q_cd[p][e] <= q_cd[p][e] - CW'(1);
                end
                if (accept[p]) begin
                    q_cd[p][tail[p]] <= enq_cd[p];
                    tail[p]          <= ptr_inc(tail[p]);
                end
                if (deq[p])
                    head[p] <= ptr_inc(head[p]);
                case ({accept[p], deq[p]})
                    2'b10:   count[p] <= count[p] + NW'(1);
                    2'b01:   count[p] <= count[p] - NW'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_test_mem_mport.sv
module tb_test_mem_mport;

    localparam int NP    = 2;
    localparam int DEPTH = 4096;
    localparam int LAT   = 1;
    localparam int QD    = 2;
    localparam int RMAX  = 3;
`ifdef TEST_MEM_RAND_DELAY_EN
    localparam int SLACK = RMAX;
`else
    localparam int SLACK = 0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NP-1:0][76:0] req_msg;
    logic [NP-1:0]       req_val;
    logic [NP-1:0]       req_rdy;
    logic [NP-1:0][46:0] resp_msg;
    logic [NP-1:0]       resp_val;
    logic [NP-1:0]       resp_rdy;

    test_mem_mport #(
        .p_num_ports  (NP),
        .p_depth_words(DEPTH),
        .p_latency    (LAT),
        .p_queue_depth(QD),
        .p_rand_max   (RMAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req_msg (req_msg),
        .req_val (req_val),
        .req_rdy (req_rdy),
        .resp_msg(resp_msg),
        .resp_val(resp_val),
        .resp_rdy(resp_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-addressed store plus per-port FIFOs of expected
    // responses, tagged with the cycle in which each request was accepted.
    logic [7:0]  mem_b [int];
    logic [46:0] exp_q [NP][$];
    int          acc_q [NP][$];
    bit [NP-1:0] acc_flag;
    logic [7:0]  deq_log [$];
    int          deq_cnt = 0;
    int          cyc = 0;
    logic [7:0]  op_ctr [NP];

    function automatic int key_of(input logic [31:0] a, input int lane);
        return int'((a >> 2) % 32'(DEPTH)) * 4 + lane;
    endfunction

    function automatic logic [46:0] model_resp(input logic [76:0] m);
        logic [2:0]  t;
        logic [31:0] a;
        logic [1:0]  len;
        logic [31:0] d;
        int          nb;
        int          lane;
        t   = m[76:74];
        a   = m[65:34];
        len = m[33:32];
        nb  = (len == 2'd0) ? 4 : int'(len);
        d   = '0;
        if (t == 3'd0) begin
            for (int i = 0; i < nb; i++) begin
                lane = int'(a[1:0]) + i;
                if (lane < 4)
                    d[8*i +: 8] = mem_b.exists(key_of(a, lane)) ? mem_b[key_of(a, lane)] : 8'h00;
            end
        end
        return {t, m[73:66], 2'b00, len, d};
    endfunction

    function automatic void model_write(input logic [76:0] m);
        logic [2:0]  t;
        logic [31:0] a;
        logic [1:0]  len;
        int          nb;
        int          lane;
        t   = m[76:74];
        a   = m[65:34];
        len = m[33:32];
        nb  = (len == 2'd0) ? 4 : int'(len);
        if (t == 3'd1 || t == 3'd2) begin
            for (int i = 0; i < nb; i++) begin
                lane = int'(a[1:0]) + i;
                if (lane < 4)
                    mem_b[key_of(a, lane)] = m[8*i +: 8];
            end
        end
    endfunction

    // Cycle monitor: sample away from the active edge, check outputs, then
    // advance the model.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            for (int p = 0; p < NP; p++) begin
                int n;
                int age;
                bit may_val;
                bit must_val;
                n        = exp_q[p].size();
                age      = (n > 0) ? cyc - acc_q[p][0] : 0;
                must_val = (n > 0) && (age >= LAT + SLACK);
                may_val  = (n > 0) && (age >= LAT);
                check($sformatf("req_rdy_p%0d", p), 64'(req_rdy[p]), 64'(n < QD));
                if (must_val)
                    check($sformatf("resp_val_due_p%0d", p), 64'(resp_val[p]), 64'(1));
                else if (!may_val)
                    check($sformatf("resp_val_idle_p%0d", p), 64'(resp_val[p]), 64'(0));
                if (resp_val[p] && n > 0)
                    check($sformatf("resp_msg_p%0d", p), 64'(resp_msg[p]), 64'(exp_q[p][0]));
                else if (!resp_val[p])
                    check($sformatf("resp_msg_zero_p%0d", p), 64'(resp_msg[p]), 64'(0));
                if (resp_val[p] && resp_rdy[p]) begin
                    deq_cnt++;
                    if (p == 0)
                        deq_log.push_back(resp_msg[0][43:36]);
                    if (n > 0) begin
                        void'(exp_q[p].pop_front());
                        void'(acc_q[p].pop_front());
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                acc_flag[p] = req_val[p] && req_rdy[p];
                if (acc_flag[p]) begin
                    exp_q[p].push_back(model_resp(req_msg[p]));
                    acc_q[p].push_back(cyc);
                end
            end
            for (int p = 0; p < NP; p++)
                if (acc_flag[p])
                    model_write(req_msg[p]);
        end else begin
            acc_flag = '0;
        end
    end

    function automatic logic [76:0] mk(input logic [2:0] t, input logic [7:0] op,
                                       input logic [31:0] a, input logic [1:0] len,
                                       input logic [31:0] d);
        return {t, op, a, len, d};
    endfunction

    task automatic issue(input int p, input logic [76:0] m);
        bit got;
        got        = 1'b0;
        req_msg[p] = m;
        req_val[p] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (req_rdy[p]) begin
                got = 1'b1;
                break;
            end
        end
        check($sformatf("issue_accepted_p%0d", p), 64'(got), 64'(1));
        @(posedge clk);
        #1;
        req_val[p] = 1'b0;
    endtask

    task automatic wait_resp(input int p, output logic [46:0] r);
        bit got;
        got = 1'b0;
        r   = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (resp_val[p] && resp_rdy[p]) begin
                r   = resp_msg[p];
                got = 1'b1;
                break;
            end
        end
        check($sformatf("resp_seen_p%0d", p), 64'(got), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int left;
        req_val  = '0;
        resp_rdy = '1;
        left     = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            left = 0;
            for (int p = 0; p < NP; p++)
                left += exp_q[p].size();
            if (left == 0)
                break;
        end
        check("drain_empty", 64'(left), 64'(0));
    endtask

    task automatic dual(input logic [76:0] m0, input logic [76:0] m1);
        req_msg[0] = m0;
        req_msg[1] = m1;
        req_val    = 2'b11;
        @(negedge clk);
        check("dual_rdy", 64'(req_rdy), 64'(2'b11));
        @(posedge clk);
        #1;
        req_val = '0;
    endtask

    function automatic logic [76:0] rand_msg(input int p);
        logic [2:0]  t;
        logic [31:0] a;
        int          r;
        r = $urandom_range(0, 9);
        if (r < 5)       t = 3'd0;
        else if (r < 7)  t = 3'd1;
        else if (r == 7) t = 3'd2;
        else             t = 3'($urandom_range(3, 7));
        a = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        op_ctr[p] = op_ctr[p] + 8'd1;
        return mk(t, op_ctr[p], a, 2'($urandom_range(0, 3)), $urandom());
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [46:0] r;
        req_msg  = '0;
        req_val  = '0;
        resp_rdy = '1;
        for (int p = 0; p < NP; p++)
            op_ctr[p] = 8'h80;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_rdy", 64'(req_rdy), 64'(0));
        check("rst_resp_val", 64'(resp_val), 64'(0));
        for (int p = 0; p < NP; p++)
            check($sformatf("rst_resp_msg_p%0d", p), 64'(resp_msg[p]), 64'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Give every word the random phase touches a known value
        for (int w = 0; w < 16; w++)
            issue(0, mk(3'd1, 8'(w), 32'(w * 4), 2'd0, $urandom()));
        drain();

        // Read back a full word
        issue(0, mk(3'd1, 8'h01, 32'h0, 2'd0, 32'hDEADBEEF));
        drain();
        issue(0, mk(3'd0, 8'h05, 32'h0, 2'd0, 32'h0));
        wait_resp(0, r);
        check("t1_data", 64'(r[31:0]), 64'(32'hDEADBEEF));
        check("t1_opaque", 64'(r[43:36]), 64'(8'h05));

        // Write on port 1, then full, single-byte and truncated reads on port 0
        issue(1, mk(3'd1, 8'h10, 32'h4, 2'd0, 32'h11223344));
        drain();
        issue(0, mk(3'd0, 8'h11, 32'h4, 2'd0, 32'h0));
        wait_resp(0, r);
        check("t2_word", 64'(r[31:0]), 64'(32'h11223344));
        issue(0, mk(3'd0, 8'h12, 32'h5, 2'd1, 32'h0));
        wait_resp(0, r);
        check("t2_byte", 64'(r[31:0]), 64'(32'h00000033));
        issue(0, mk(3'd0, 8'h13, 32'h6, 2'd3, 32'h0));
        wait_resp(0, r);
        check("t2_lanes_dropped", 64'(r[31:0]), 64'(32'h00001122));
        issue(0, mk(3'd1, 8'h14, 32'h7, 2'd1, 32'h000000AB));
        drain();
        issue(1, mk(3'd0, 8'h15, 32'h4, 2'd0, 32'h0));
        wait_resp(1, r);
        check("t2_byte_write", 64'(r[31:0]), 64'(32'hAB223344));

        // Same-cycle write conflicts: the higher port index wins
        dual(mk(3'd1, 8'h20, 32'h8, 2'd0, 32'hAAAAAAAA), mk(3'd1, 8'h21, 32'h8, 2'd0, 32'h55555555));
        drain();
        issue(0, mk(3'd0, 8'h22, 32'h8, 2'd0, 32'h0));
        wait_resp(0, r);
        check("t3_conflict", 64'(r[31:0]), 64'(32'h55555555));
        dual(mk(3'd1, 8'h23, 32'h8, 2'd2, 32'h00001111), mk(3'd1, 8'h24, 32'h9, 2'd1, 32'h00000022));
        drain();
        issue(1, mk(3'd0, 8'h25, 32'hF0F0_4008, 2'd0, 32'h0));
        wait_resp(1, r);
        check("t3_partial_wrap", 64'(r[31:0]), 64'(32'h55552211));

        // Backpressure: the queue fills after two accepts and stays full
        drain();
        deq_log.delete();
        resp_rdy[0] = 1'b0;
        issue(0, mk(3'd0, 8'h30, 32'h0, 2'd0, 32'h0));
        issue(0, mk(3'd0, 8'h31, 32'h4, 2'd0, 32'h0));
        req_msg[0] = mk(3'd0, 8'h32, 32'h8, 2'd0, 32'h0);
        req_val[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t4_full_rdy", 64'(req_rdy[0]), 64'(0));
        end
        @(posedge clk);
        #1;
        resp_rdy[0] = 1'b1;
        issue(0, mk(3'd0, 8'h32, 32'h8, 2'd0, 32'h0));
        drain();
        check("t4_count", 64'(deq_log.size()), 64'(3));
        for (int i = 0; i < 3; i++)
            check($sformatf("t4_order%0d", i), 64'((i < deq_log.size()) ? deq_log[i] : 8'hxx), 64'(8'h30 + 8'(i)));

        // Reset with requests still outstanding
        resp_rdy = '0;
        issue(0, mk(3'd0, 8'h40, 32'h8, 2'd0, 32'h0));
        issue(1, mk(3'd0, 8'h41, 32'h8, 2'd0, 32'h0));
        #1 rst = 1'b1;
        for (int p = 0; p < NP; p++) begin
            exp_q[p].delete();
            acc_q[p].delete();
        end
        #1;
        check("t5_req_rdy", 64'(req_rdy), 64'(0));
        check("t5_resp_val", 64'(resp_val), 64'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        resp_rdy = '1;
        deq_cnt  = 0;
        repeat (6) @(posedge clk);
        #1;
        check("t5_no_stale", 64'(deq_cnt), 64'(0));
        issue(0, mk(3'd0, 8'h42, 32'h8, 2'd0, 32'h0));
        wait_resp(0, r);
        check("t5_array_kept", 64'(r[31:0]), 64'(32'h55552211));

        // Random traffic on both ports with random response backpressure
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!req_val[p] || acc_flag[p]) begin
                    if ($urandom_range(0, 9) < 7) begin
                        req_msg[p] = rand_msg(p);
                        req_val[p] = 1'b1;
                    end else begin
                        req_val[p] = 1'b0;
                    end
                end
                resp_rdy[p] = ($urandom_range(0, 9) < 7);
            end
            @(posedge clk);
            #1;
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
